// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue/decode slice.
//   - ALU func codes understood by the combinational execute-stage ALU
//   - RV64I major opcode constants
//   - alu_bundle_t: one decoded ALU operation (operands, func, flags)
//   - sext_i12: sign-extension helper for 12-bit immediates
package alu_pkg;

  localparam int ALU_XLEN = 64;
  localparam int ALU_ILEN = 32;

  // ALU func codes. For register/immediate ALU ops the low three bits equal
  // funct3, and bit 3 distinguishes SUB/SRA from ADD/SRL.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1110;

  // RV64I major opcodes (instr[6:0]).
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [3:0]          func;
    logic                is_word;
    logic                illegal;
  } alu_bundle_t;

  function automatic logic [ALU_XLEN-1:0] sext_i12(input logic [11:0] imm);
    return {{(ALU_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational RV64I -> ALU operand/func decode.
// Ports:
//   instr   in  instruction word
//   pc      in  instruction PC (SrcA for AUIPC/JAL)
//   rs1_val in  forwarded rs1 value
//   rs2_val in  forwarded rs2 value
//   dec     out decoded bundle {a, b, func, is_word, illegal}
// Any unsupported opcode or funct encoding yields illegal=1 with a=b=0 and
// func=ADD so the entry can travel down the pipe and trap there.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [ALU_ILEN-1:0] instr,
  input  logic [ALU_XLEN-1:0] pc,
  input  logic [ALU_XLEN-1:0] rs1_val,
  input  logic [ALU_XLEN-1:0] rs2_val,
  output alu_bundle_t         dec
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [5:0]          funct6;
  logic [ALU_XLEN-1:0] imm_i;
  logic [ALU_XLEN-1:0] imm_s;
  logic [ALU_XLEN-1:0] imm_u;
  logic [ALU_XLEN-1:0] shamt6;
  logic [ALU_XLEN-1:0] shamt5;
  logic                unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct6 = instr[31:26];
  assign imm_i  = sext_i12(instr[31:20]);
  assign imm_s  = sext_i12({instr[31:25], instr[11:7]});
  assign imm_u  = {{(ALU_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign shamt6 = {{(ALU_XLEN-6){1'b0}}, instr[25:20]};
  assign shamt5 = {{(ALU_XLEN-5){1'b0}}, instr[24:20]};

  // Register specifier bits are consumed by the register file, not here.
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    dec         = '0;
    dec.func    = ALU_ADD;
    dec.is_word = (opcode == OP_32) || (opcode == OP_IMM_32);

    case (opcode)
      OP, OP_32: begin
        dec.a = rs1_val;
        dec.b = rs2_val;
        if (funct7 == 7'b0000000) begin
          dec.func = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 &&
                     (funct3 == 3'b000 || funct3 == 3'b101)) begin
          // {1,000} = SUB, {1,101} = SRA
          dec.func = {1'b1, funct3};
        end else begin
          dec.illegal = 1'b1;
        end
        // The word forms only exist for ADD/SUB/SLL/SRL/SRA.
        if (opcode == OP_32 && !(funct3 inside {3'b000, 3'b001, 3'b101})) begin
          dec.illegal = 1'b1;
        end
      end

      OP_IMM: begin
        dec.a = rs1_val;
        dec.b = imm_i;
        case (funct3)
          3'b001: begin
            dec.b    = shamt6;
            dec.func = ALU_SLL;
            if (funct6 != 6'b000000) dec.illegal = 1'b1;
          end
          3'b101: begin
            dec.b = shamt6;
            if (funct6 == 6'b000000)      dec.func = ALU_SRL;
            else if (funct6 == 6'b010000) dec.func = ALU_SRA;
            else                          dec.illegal = 1'b1;
          end
          default: dec.func = {1'b0, funct3};
        endcase
      end

      OP_IMM_32: begin
        dec.a = rs1_val;
        dec.b = imm_i;
        case (funct3)
          3'b000: dec.func = ALU_ADD;
          3'b001: begin
            dec.b    = shamt5;
            dec.func = ALU_SLL;
            if (funct7 != 7'b0000000) dec.illegal = 1'b1;
          end
          3'b101: begin
            dec.b = shamt5;
            if (funct7 == 7'b0000000)      dec.func = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.func = ALU_SRA;
            else                           dec.illegal = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end

      LUI: begin
        dec.a    = '0;
        dec.b    = imm_u;
        dec.func = ALU_PASSB;
      end

      AUIPC: begin
        dec.a = pc;
        dec.b = imm_u;
      end

      LOAD, JALR: begin
        dec.a = rs1_val;
        dec.b = imm_i;
      end

      STORE: begin
        dec.a = rs1_val;
        dec.b = imm_s;
      end

      JAL: begin
        // Link value pc+4.
        dec.a = pc;
        dec.b = {{(ALU_XLEN-3){1'b0}}, 3'd4};
      end

      BRANCH: begin
        dec.a = rs1_val;
        dec.b = rs2_val;
        case (funct3[2:1])
          2'b00:   dec.func = ALU_SUB;   // BEQ/BNE compare via zero result
          2'b10:   dec.func = ALU_SLT;   // BLT/BGE
          2'b11:   dec.func = ALU_SLTU;  // BLTU/BGEU
          default: dec.illegal = 1'b1;   // funct3 010/011
        endcase
      end

      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.a    = '0;
      dec.b    = '0;
      dec.func = ALU_ADD;
    end
  end

endmodule

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: ID/EX boundary for the ALU. Decodes one RV64I
// instruction into ALU operands/func and holds it in a valid/ready
// pipeline register backed by one skid register.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ready is registered
//   in_instr, in_pc      instruction word and PC
//   in_rs1_val/rs2_val   forwarded register operands
//   flush                squash every held entry on the next edge
//   out_valid/out_ready  downstream handshake to the execute stage
//   alu_a, alu_b         ALU SrcA/SrcB
//   alu_func             ALU func code
//   out_is_word          OP-32/OP-IMM-32 result needs 32-bit sign extension
//   out_illegal          opcode/funct not supported (trap downstream)
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_func,
  output logic            out_is_word,
  output logic            out_illegal
);

  alu_bundle_t dec;

  alu_bundle_t main_q, main_d;
  logic        main_valid_q, main_valid_d;
  alu_bundle_t skid_q, skid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;

  logic        accept;
  logic        consume;

  alu_op_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .dec     (dec)
  );

  assign accept  = in_valid && in_ready_q;
  assign consume = main_valid_q && out_ready;

  // The skid register is only ever occupied while main is occupied, so
  // in_ready_q (= !skid full) is low whenever skid holds data and a new
  // accept can never coincide with a skid drain.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      // Main is free (or being emptied): refill it, oldest entry first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry behind it.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign alu_a       = main_q.a;
  assign alu_b       = main_q.b;
  assign alu_func    = main_q.func;
  assign out_is_word = main_q.is_word;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// tb_alu_issue_decode: scoreboard bench for alu_issue_decode. Expected
// bundles are hand-derived per instruction, pushed when the bench's own
// occupancy model says the stage accepts, and compared while at the head.
module tb_alu_issue_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic [63:0] in_rs1_val = '0;
  logic [63:0] in_rs2_val = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_func;
  logic        out_is_word;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_decode #(.XLEN(64), .ILEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .out_is_word (out_is_word),
    .out_illegal (out_illegal)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  func;
    logic        w;
    logic        il;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tab [NVEC];
  vec_t sb [$];

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;
  int cur_idx = 0;
  bit accepted = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int idx, input logic v);
    cur_idx    = idx;
    in_valid   = v;
    in_instr   = tab[idx].instr;
    in_pc      = tab[idx].pc;
    in_rs1_val = tab[idx].rs1;
    in_rs2_val = tab[idx].rs2;
  endtask

  // Inputs are driven just after a negedge; sample 1 unit later, update the
  // scoreboard for the coming posedge, then wait for the next negedge.
  task automatic cycle();
    bit   model_ready;
    vec_t e;
    #1;
    model_ready = (sb.size() < 2);
    check_eq("out_valid", {63'b0, out_valid}, {63'b0, (sb.size() > 0)});
    check_eq("in_ready", {63'b0, in_ready}, {63'b0, model_ready});
    if (sb.size() > 0) begin
      e = sb[0];
      check_eq("alu_a", alu_a, e.a);
      check_eq("alu_b", alu_b, e.b);
      check_eq("alu_func", {60'b0, alu_func}, {60'b0, e.func});
      check_eq("out_is_word", {63'b0, out_is_word}, {63'b0, e.w});
      check_eq("out_illegal", {63'b0, out_illegal}, {63'b0, e.il});
    end
    accepted = 1'b0;
    if (flush) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && out_ready) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: instr=%h a=%h b=%h func=%h word=%0b illegal=%0b",
                 txn, e.instr, alu_a, alu_b, alu_func, out_is_word, out_illegal);
      end
      if (in_valid && model_ready) begin
        sb.push_back(tab[cur_idx]);
        accepted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            instr         pc              rs1                     rs2    a                       b                       func  w  il
    tab[0]  = '{32'hFFF10093, 64'h0,    64'd5,                  64'd0, 64'd5,                  64'hFFFFFFFFFFFFFFFF, 4'h0, 1'b0, 1'b0}; // ADDI -1
    tab[1]  = '{32'h402081B3, 64'h0,    64'd10,                 64'd3, 64'd10,                 64'd3,                4'h8, 1'b0, 1'b0}; // SUB
    tab[2]  = '{32'h40335293, 64'h0,    64'h8000000000000010,   64'd0, 64'h8000000000000010,   64'd3,                4'hD, 1'b0, 1'b0}; // SRAI 3
    tab[3]  = '{32'h800000B7, 64'h0,    64'd77,                 64'd0, 64'd0,                  64'hFFFFFFFF80000000, 4'hE, 1'b0, 1'b0}; // LUI
    tab[4]  = '{32'h0000007F, 64'h40,   64'd7,                  64'd9, 64'd0,                  64'd0,                4'h0, 1'b0, 1'b1}; // bad opcode
    tab[5]  = '{32'h402081BB, 64'h0,    64'd1,                  64'd2, 64'd1,                  64'd2,                4'h8, 1'b1, 1'b0}; // SUBW
    tab[6]  = '{32'h01F0909B, 64'h0,    64'h1234,               64'd0, 64'h1234,               64'd31,               4'h1, 1'b1, 1'b0}; // SLLIW 31
    tab[7]  = '{32'h12345097, 64'h1000, 64'd0,                  64'd0, 64'h1000,               64'h12345000,         4'h0, 1'b0, 1'b0}; // AUIPC
    tab[8]  = '{32'hFE20BC23, 64'h0,    64'h100,                64'd5, 64'h100,                64'hFFFFFFFFFFFFFFF8, 4'h0, 1'b0, 1'b0}; // SD -8
    tab[9]  = '{32'h0080006F, 64'h2000, 64'd3,                  64'd0, 64'h2000,               64'd4,                4'h0, 1'b0, 1'b0}; // JAL
    tab[10] = '{32'h0020E063, 64'h0,    64'd1,                  64'd2, 64'd1,                  64'd2,                4'h3, 1'b0, 1'b0}; // BLTU
    tab[11] = '{32'h0020A063, 64'h0,    64'd1,                  64'd2, 64'd0,                  64'd0,                4'h0, 1'b0, 1'b1}; // branch f3=010
    tab[12] = '{32'h022081B3, 64'h0,    64'd6,                  64'd7, 64'd0,                  64'd0,                4'h0, 1'b0, 1'b1}; // MUL (no M ext)
    tab[13] = '{32'h04335293, 64'h0,    64'd6,                  64'd0, 64'd0,                  64'd0,                4'h0, 1'b0, 1'b1}; // bad funct6 shift
    tab[14] = '{32'h00C08067, 64'h0,    64'h3000,               64'd0, 64'h3000,               64'd12,               4'h0, 1'b0, 1'b0}; // JALR +12
    tab[15] = '{32'h0020B1B3, 64'h0,    64'd4,                  64'd8, 64'd4,                  64'd8,                4'h3, 1'b0, 1'b0}; // SLTU
    tab[16] = '{32'h80016093, 64'h0,    64'd9,                  64'd0, 64'd9,                  64'hFFFFFFFFFFFFF800, 4'h6, 1'b0, 1'b0}; // ORI -2048
    tab[17] = '{32'h03F09093, 64'h0,    64'd2,                  64'd0, 64'd2,                  64'd63,               4'h1, 1'b0, 1'b0}; // SLLI 63

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check_eq("rst_alu_a", alu_a, 64'd0);
    check_eq("rst_alu_b", alu_b, 64'd0);
    check_eq("rst_alu_func", {60'b0, alu_func}, 64'd0);
    check_eq("rst_is_word", {63'b0, out_is_word}, 64'd0);
    check_eq("rst_illegal", {63'b0, out_illegal}, 64'd0);
    rst_n = 1'b1;

    // Full-rate stream of every decode case.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      set_in(i, 1'b1);
      cycle();
      check_eq("stream_in_ready", {63'b0, in_ready}, 64'd1);
    end
    set_in(0, 1'b0);
    repeat (3) cycle();

    // Backpressure: three offered, two taken, outputs hold the first.
    out_ready = 1'b0;
    set_in(0, 1'b1);
    cycle();
    set_in(1, 1'b1);
    cycle();
    set_in(2, 1'b1);
    repeat (3) begin
      cycle();
      check_eq("bp_in_ready", {63'b0, in_ready}, 64'd0);
      check_eq("bp_hold_a", alu_a, 64'd5);
    end
    out_ready = 1'b1;
    cycle();
    cycle();
    set_in(0, 1'b0);
    repeat (4) cycle();

    // Flush with both registers full, new instruction dropped.
    out_ready = 1'b0;
    set_in(3, 1'b1);
    cycle();
    set_in(4, 1'b1);
    cycle();
    set_in(5, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(0, 1'b0);
    check_eq("flush_full_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("flush_full_in_ready", {63'b0, in_ready}, 64'd1);
    cycle();

    // Flush with one entry while in_ready=1: the offered instruction is dropped.
    set_in(3, 1'b1);
    cycle();
    set_in(6, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(0, 1'b0);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    set_in(1, 1'b1);
    cycle();
    set_in(0, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("arst_in_ready", {63'b0, in_ready}, 64'd1);
    check_eq("arst_alu_a", alu_a, 64'd0);
    check_eq("arst_alu_b", alu_b, 64'd0);
    check_eq("arst_alu_func", {60'b0, alu_func}, 64'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Random handshakes with occasional flushes.
    repeat (300) begin
      set_in(int'($urandom_range(0, NVEC - 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    flush = 1'b0;
    set_in(0, 1'b0);
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
